// File: rtl/ir_pkg.sv
// Shared types and constants for the IR key scheduler.
// The REPEAT_FILTER_EN macro (used by ir_key_scheduler) enables auto-repeat suppression.
package ir_pkg;

  localparam int unsigned KEY_W       = 8;
  localparam int unsigned HOLD_W      = 16;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned HOLDOFF_DEF = 1000;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ingress_state_t;

endpackage

// File: rtl/ir_key_fifo.sv
// Show-ahead key FIFO with a registered head word and registered status flags.
module ir_key_fifo
  import ir_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [KEY_W-1:0]         din,
  output logic [KEY_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [KEY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CNT_W-1:0] cnt_next;
  logic [KEY_W-1:0] head_next;
  logic             do_push, do_pop;

  // Next pointer/count state; the head bypasses memory when the new word lands at the next read slot.
  always_comb begin
    do_push   = push & ~full;
    do_pop    = pop & valid;
    rd_next   = rd_ptr + PTR_W'(do_pop);
    wr_next   = wr_ptr + PTR_W'(do_push);
    cnt_next  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    head_next = mem[rd_next];
    if (do_push && (wr_ptr == rd_next)) begin
      head_next = din;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
      end
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      count  <= cnt_next;
      dout   <= head_next;
      valid  <= (cnt_next != '0);
      empty  <= (cnt_next == '0);
      full   <= (cnt_next == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/ir_key_scheduler.sv
// Ingress edge detection, optional auto-repeat filter (REPEAT_FILTER_EN) and key queueing.
// Macro REPEAT_FILTER_EN: when undefined the holdoff counter and last-key register are not built.
module ir_key_scheduler
  import ir_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned HOLDOFF = HOLDOFF_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [KEY_W-1:0]       Key_in,
  input  logic                   Key_ready,
  output logic [KEY_W-1:0]       Key_out,
  output logic                   Key_valid,
  input  logic                   Key_ack,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  input  logic                   Overflow_clr
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ir_key_scheduler: DEPTH must be a power of two in 2..16");
  end
  if (HOLDOFF < 1 || HOLDOFF > 65535) begin : g_bad_holdoff
    $error("ir_key_scheduler: HOLDOFF must be in 1..65535");
  end

  ingress_state_t state_q, state_d;
  logic           eval;
  logic           reject;
  logic           accept;
  logic           fifo_full;
  logic           fifo_empty;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // One evaluation per Ready pulse: evaluate on entry, then wait for Ready to drop.
  always_comb begin
    state_d = state_q;
    eval    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Key_ready) begin
          eval    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!Key_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef REPEAT_FILTER_EN
  logic [KEY_W-1:0]  last_key_q;
  logic [HOLD_W-1:0] holdoff_q;

  // Every evaluation restarts the window, so a held-down key stays suppressed.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_key_q <= '0;
      holdoff_q  <= '0;
    end else if (eval) begin
      last_key_q <= Key_in;
      holdoff_q  <= HOLD_W'(HOLDOFF);
    end else if (holdoff_q != '0) begin
      holdoff_q  <= holdoff_q - HOLD_W'(1);
    end
  end

  assign reject = (Key_in == last_key_q) && (holdoff_q != '0);
`else
  assign reject = 1'b0;
`endif

  assign accept = eval & ~reject;

  // Drop on a full queue is judged on pre-pop occupancy; a drop outranks a clear.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Overflow <= 1'b0;
    end else if (accept && fifo_full) begin
      Overflow <= 1'b1;
    end else if (Overflow_clr) begin
      Overflow <= 1'b0;
    end
  end

  ir_key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .push    (accept),
    .pop     (Key_ack),
    .din     (Key_in),
    .dout    (Key_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .valid   (Key_valid),
    .count   (Count)
  );

  logic unused_empty;
  assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_ir_key_scheduler.sv
// Directed bench for ir_key_scheduler (DEPTH=4, HOLDOFF=100); expected values are hand-derived.
module tb_ir_key_scheduler;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [7:0] Key_in;
  logic       Key_ready;
  logic [7:0] Key_out;
  logic       Key_valid;
  logic       Key_ack;
  logic [2:0] Count;
  logic       Overflow;
  logic       Overflow_clr;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  ir_key_scheduler #(
    .DEPTH   (4),
    .HOLDOFF (100)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Key_in       (Key_in),
    .Key_ready    (Key_ready),
    .Key_out      (Key_out),
    .Key_valid    (Key_valid),
    .Key_ack      (Key_ack),
    .Count        (Count),
    .Overflow     (Overflow),
    .Overflow_clr (Overflow_clr)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  // Ready high for `width` clocks, then one low clock.
  task automatic frame(input logic [7:0] key, input int width = 3);
    Key_in    = key;
    Key_ready = 1'b1;
    tick(width);
    Key_ready = 1'b0;
    tick(1);
  endtask

  initial begin
    Reset_n = 1'b0; Key_in = '0; Key_ready = 1'b0; Key_ack = 1'b0; Overflow_clr = 1'b0;
    tick(2);
    check("rst_valid", int'(Key_valid), 0);
    check("rst_count", int'(Count), 0);
    check("rst_ovf", int'(Overflow), 0);
    check("rst_out", int'(Key_out), 0);
    Reset_n = 1'b1;
    tick(1);

    // Single 3-clock frame: one push, visible one edge later
    Key_in = 8'h45; Key_ready = 1'b1;
    tick(1);
    check("single_valid", int'(Key_valid), 1);
    check("single_out", int'(Key_out), 'h45);
    check("single_count", int'(Count), 1);
    tick(2); Key_ready = 1'b0; tick(1);
    check("single_once", int'(Count), 1);
    Key_ack = 1'b1; tick(1); Key_ack = 1'b0;
    check("single_pop_count", int'(Count), 0);
    check("single_pop_valid", int'(Key_valid), 0);
    Key_ack = 1'b1; tick(1); Key_ack = 1'b0;
    check("ack_empty_count", int'(Count), 0);

    // Fill beyond depth
    for (int k = 1; k <= 5; k++) frame(8'(k));
    check("fill_count", int'(Count), 4);
    check("fill_out", int'(Key_out), 1);
    check("fill_ovf", int'(Overflow), 1);
    Overflow_clr = 1'b1; tick(1); Overflow_clr = 1'b0;
    check("ovf_clr", int'(Overflow), 0);
    Key_ack = 1'b1; tick(1);
    check("drain_out2", int'(Key_out), 2);
    tick(1);
    check("drain_out3", int'(Key_out), 3);
    tick(1);
    check("drain_out4", int'(Key_out), 4);
    tick(1); Key_ack = 1'b0;
    check("drain_empty", int'(Count), 0);

    // Push and pop together at Count=2
    frame(8'h21); frame(8'h22);
    Key_in = 8'h23; Key_ready = 1'b1; Key_ack = 1'b1;
    tick(1); Key_ack = 1'b0;
    check("pp2_count", int'(Count), 2);
    check("pp2_out", int'(Key_out), 'h22);
    tick(2); Key_ready = 1'b0; tick(1);
    Key_ack = 1'b1; tick(1); Key_ack = 1'b0;
    check("pp2_order", int'(Key_out), 'h23);
    Key_ack = 1'b1; tick(1); Key_ack = 1'b0;
    check("pp2_empty", int'(Count), 0);

    // Push and pop together at Count=4, clear in the same cycle loses to the drop
    for (int k = 'h31; k <= 'h34; k++) frame(8'(k));
    check("pp4_pre", int'(Count), 4);
    Key_in = 8'h35; Key_ready = 1'b1; Key_ack = 1'b1; Overflow_clr = 1'b1;
    tick(1); Key_ack = 1'b0; Overflow_clr = 1'b0;
    check("pp4_count", int'(Count), 3);
    check("pp4_ovf_setwins", int'(Overflow), 1);
    check("pp4_out", int'(Key_out), 'h32);
    tick(2); Key_ready = 1'b0; tick(1);
    Key_ack = 1'b1; tick(1);
    check("pp4_out33", int'(Key_out), 'h33);
    tick(1);
    check("pp4_out34", int'(Key_out), 'h34);
    tick(1); Key_ack = 1'b0;
    check("pp4_empty", int'(Count), 0);
    Overflow_clr = 1'b1; tick(1); Overflow_clr = 1'b0;
    check("pp4_ovf_clr", int'(Overflow), 0);

    // Reset mid-frame, Ready still high after release
    Key_in = 8'h50; Key_ready = 1'b1;
    tick(1);
    check("mid_pre_count", int'(Count), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(Key_valid), 0);
    check("mid_rst_count", int'(Count), 0);
    tick(1);
    Reset_n = 1'b1;
    tick(1);
    check("mid_new_count", int'(Count), 1);
    check("mid_new_out", int'(Key_out), 'h50);
    tick(1); Key_ready = 1'b0; tick(1);
    check("mid_once", int'(Count), 1);
    Key_ack = 1'b1; tick(1); Key_ack = 1'b0;
    check("mid_empty", int'(Count), 0);

    // Repeat filter timeline: frames at t=0, 50, 200, 210
    frame(8'h16);           // t=0..3
    tick(46);
    frame(8'h16);           // t=50
`ifdef REPEAT_FILTER_EN
    check("rpt_t50", int'(Count), 1);
`else
    check("rpt_t50", int'(Count), 2);
`endif
    tick(146);
    frame(8'h16);           // t=200
    tick(6);
    frame(8'h18);           // t=210
`ifdef REPEAT_FILTER_EN
    check("rpt_final", int'(Count), 3);
`else
    check("rpt_final", int'(Count), 4);
`endif
    check("rpt_head", int'(Key_out), 'h16);
    check("rpt_ovf", int'(Overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
